// File: rtl/calc1_port_driver.sv
// calc1_port_driver
//   Transaction front end for one calc1 request port. It accepts a complete
//   command (cmd, op1, op2, tag) over a valid/ready handshake. It then drives
//   the command onto the calc1 two-cycle port protocol (cmd+op1, then op2).
//   It waits for the calc1 response and returns it with a latency count.
//   A watchdog forces a timeout result when the port never answers.
//
// Parameters
//   TIMEOUT  max WAIT cycles before a timeout result is forced (2..255)
//   LAT_W    width of rsp_latency, saturating at all-ones
//
// Ports
//   c_clk, reset                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_cmd/op1/op2/tag          request payload
//   port_cmd/port_data           to calc1 reqN_cmd_in / reqN_data_in
//   port_resp/port_dout          from calc1 out_respN / out_dataN
//   rsp_valid/rsp_ready          response handshake
//   rsp_code/data/tag            captured response and echoed tag
//   rsp_timeout                  response was forced by the watchdog
//   rsp_latency                  cycles from op2 drive to response capture
//   stray_resp                   one-cycle pulse: nonzero port_resp outside WAIT
//
// Vectors use [0:N-1] ordering, so bit 0 is the MSB. All outputs are registered.

module calc1_port_driver #(
   parameter int TIMEOUT = 64,
   parameter int LAT_W   = 8
) (
   input  logic             c_clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [0:3]       req_cmd,
   input  logic [0:31]      req_op1,
   input  logic [0:31]      req_op2,
   input  logic [0:1]       req_tag,
   output logic [0:3]       port_cmd,
   output logic [0:31]      port_data,
   input  logic [0:1]       port_resp,
   input  logic [0:31]      port_dout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [0:1]       rsp_code,
   output logic [0:31]      rsp_data,
   output logic [0:1]       rsp_tag,
   output logic             rsp_timeout,
   output logic [0:LAT_W-1] rsp_latency,
   output logic             stray_resp
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND1,
      ST_SEND2,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [0:LAT_W-1] LAT_MAX     = {LAT_W{1'b1}};
   // The watchdog fires on the last permitted WAIT cycle (count TIMEOUT-1).
   localparam logic [0:7]       TIMEOUT_CNT = 8'(TIMEOUT - 1);

   state_t            state_reg;
   logic              req_ready_reg;
   logic [0:3]        port_cmd_reg;
   logic [0:31]       port_data_reg;
   logic [0:31]       op2_reg;
   logic [0:1]        tag_reg;
   logic [0:7]        wait_cnt_reg;   // watchdog, independent of LAT_W
   logic [0:LAT_W-1]  lat_cnt_reg;    // saturating latency counter
   logic [0:LAT_W-1]  lat_next;
   logic              rsp_valid_reg;
   logic [0:1]        rsp_code_reg;
   logic [0:31]       rsp_data_reg;
   logic [0:1]        rsp_tag_reg;
   logic              rsp_timeout_reg;
   logic [0:LAT_W-1]  rsp_latency_reg;
   logic              stray_resp_reg;

   // Latency for the current WAIT cycle: count so far plus this cycle, saturated.
   always_comb begin
      lat_next = LAT_MAX;
      if (lat_cnt_reg != LAT_MAX) begin
         lat_next = lat_cnt_reg + LAT_W'(1);
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         req_ready_reg   <= 1'b0;
         port_cmd_reg    <= '0;
         port_data_reg   <= '0;
         op2_reg         <= '0;
         tag_reg         <= '0;
         wait_cnt_reg    <= '0;
         lat_cnt_reg     <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_code_reg    <= '0;
         rsp_data_reg    <= '0;
         rsp_tag_reg     <= '0;
         rsp_timeout_reg <= 1'b0;
         rsp_latency_reg <= '0;
         stray_resp_reg  <= 1'b0;
      end else begin
         // A response outside WAIT is only flagged; it never touches the result.
         stray_resp_reg <= (port_resp != 2'b00) && (state_reg != ST_WAIT);

         case (state_reg)
            ST_IDLE: begin
               req_ready_reg <= 1'b1;
               if (req_valid && req_ready_reg) begin
                  // The first protocol beat is loaded here so it appears
                  // on the port while the FSM sits in SEND1.
                  req_ready_reg <= 1'b0;
                  port_cmd_reg  <= req_cmd;
                  port_data_reg <= req_op1;
                  op2_reg       <= req_op2;
                  tag_reg       <= req_tag;
                  state_reg     <= ST_SEND1;
               end
            end

            ST_SEND1: begin
               port_cmd_reg  <= '0;
               port_data_reg <= op2_reg;
               state_reg     <= ST_SEND2;
            end

            ST_SEND2: begin
               port_data_reg <= '0;
               wait_cnt_reg  <= '0;
               lat_cnt_reg   <= '0;
               state_reg     <= ST_WAIT;
            end

            ST_WAIT: begin
               wait_cnt_reg <= wait_cnt_reg + 8'd1;
               lat_cnt_reg  <= lat_next;
               if (port_resp != 2'b00) begin
                  rsp_code_reg    <= port_resp;
                  rsp_data_reg    <= port_dout;
                  rsp_tag_reg     <= tag_reg;
                  rsp_timeout_reg <= 1'b0;
                  rsp_latency_reg <= lat_next;
                  rsp_valid_reg   <= 1'b1;
                  state_reg       <= ST_DONE;
               end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                  // lat_next equals TIMEOUT here, saturated to LAT_W.
                  rsp_code_reg    <= 2'd3;
                  rsp_data_reg    <= '0;
                  rsp_tag_reg     <= tag_reg;
                  rsp_timeout_reg <= 1'b1;
                  rsp_latency_reg <= lat_next;
                  rsp_valid_reg   <= 1'b1;
                  state_reg       <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_reg;
   assign port_cmd    = port_cmd_reg;
   assign port_data   = port_data_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_code    = rsp_code_reg;
   assign rsp_data    = rsp_data_reg;
   assign rsp_tag     = rsp_tag_reg;
   assign rsp_timeout = rsp_timeout_reg;
   assign rsp_latency = rsp_latency_reg;
   assign stray_resp  = stray_resp_reg;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Testbench for calc1_port_driver. The bench plays the calc1 port itself by
// driving port_resp/port_dout on a chosen WAIT cycle. Expected results are
// queued when a request is issued and compared when the response appears.
module tb_calc1_port_driver;

   localparam int TO = 16;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_cmd = '0;
   logic [31:0] req_op1 = '0;
   logic [31:0] req_op2 = '0;
   logic [1:0]  req_tag = '0;
   logic [3:0]  port_cmd;
   logic [31:0] port_data;
   logic [1:0]  port_resp = '0;
   logic [31:0] port_dout = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_code;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_tag;
   logic        rsp_timeout;
   logic [7:0]  rsp_latency;
   logic        stray_resp;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] data;
      logic [1:0]  tag;
      logic        to;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   calc1_port_driver #(.TIMEOUT(TO), .LAT_W(8)) dut (
      .c_clk(c_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
      .port_cmd(port_cmd), .port_data(port_data),
      .port_resp(port_resp), .port_dout(port_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_timeout(rsp_timeout), .rsp_latency(rsp_latency),
      .stray_resp(stray_resp)
   );

   always #5 c_clk = ~c_clk;

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // Issue one request and play the calc1 side. resp_cyc is the WAIT cycle
   // (1-based) carrying the response; 0 means the port never answers.
   task automatic run_txn(input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [1:0] tag,
                          input int resp_cyc, input logic [1:0] resp,
                          input logic [31:0] dout, input bit stray2);
      exp_t e;
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
      req_valid = 1'b1; req_cmd = cmd; req_op1 = op1; req_op2 = op2; req_tag = tag;
      step();
      req_valid = 1'b0;
      e.code = (resp_cyc != 0) ? resp : 2'd3;
      e.data = (resp_cyc != 0) ? dout : 32'h0;
      e.tag  = tag;
      e.to   = (resp_cyc == 0);
      e.lat  = (resp_cyc != 0) ? resp_cyc : TO;
      sb.push_back(e);
      checks++;
      if (port_cmd !== cmd || port_data !== op1) begin
         errors++; $display("FAIL send1: got cmd=%h data=%h want cmd=%h data=%h", port_cmd, port_data, cmd, op1);
      end
      step();
      checks++;
      if (port_cmd !== 4'h0 || port_data !== op2) begin
         errors++; $display("FAIL send2: got cmd=%h data=%h want cmd=0 data=%h", port_cmd, port_data, op2);
      end
      if (stray2) begin port_resp = 2'd1; port_dout = 32'hDEAD_BEEF; end
      step();
      port_resp = '0; port_dout = '0;
      checks++;
      if (port_cmd !== 4'h0 || port_data !== 32'h0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL wait_entry: got cmd=%h data=%h valid=%b want 0/0/0", port_cmd, port_data, rsp_valid);
      end
      if (stray2) begin
         checks++;
         if (stray_resp !== 1'b1) begin errors++; $display("FAIL stray_send2: got %b want 1", stray_resp); end
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 300) begin
         if (n + 1 == resp_cyc) begin port_resp = resp; port_dout = dout; end
         step();
         n++;
         port_resp = '0; port_dout = '0;
         if (stray2 && n == 1) begin
            checks++;
            if (stray_resp !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", stray_resp); end
         end
      end
      checks++;
      if (rsp_valid !== 1'b1 || n != e.lat) begin
         errors++; $display("FAIL wait_len: got valid=%b after %0d cycles want 1 after %0d", rsp_valid, n, e.lat);
      end
   endtask

   // Pop the expected result, compare, optionally stall rsp_ready, then hand off.
   task automatic collect(input int hold);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL sb_empty: got 0 entries want 1"); return; end
      e = sb.pop_front();
      checks++;
      if (rsp_code !== e.code) begin errors++; $display("FAIL rsp_code: got %0d want %0d", rsp_code, e.code); end
      checks++;
      if (rsp_data !== e.data) begin errors++; $display("FAIL rsp_data: got %h want %h", rsp_data, e.data); end
      checks++;
      if (rsp_tag !== e.tag) begin errors++; $display("FAIL rsp_tag: got %0d want %0d", rsp_tag, e.tag); end
      checks++;
      if (rsp_timeout !== e.to) begin errors++; $display("FAIL rsp_timeout: got %b want %b", rsp_timeout, e.to); end
      checks++;
      if (int'(rsp_latency) != e.lat) begin errors++; $display("FAIL rsp_latency: got %0d want %0d", rsp_latency, e.lat); end
      $display("txn tag=%0d code=%0d data=%h latency=%0d timeout=%0b", rsp_tag, rsp_code, rsp_data, rsp_latency, rsp_timeout);
      for (int i = 0; i < hold; i++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_code !== e.code || rsp_data !== e.data ||
             rsp_tag !== e.tag || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b code=%0d data=%h tag=%0d ready=%b want 1/%0d/%h/%0d/0",
                     rsp_valid, rsp_code, rsp_data, rsp_tag, req_ready, e.code, e.data, e.tag);
         end
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL handoff: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if ({port_cmd, port_data, req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag,
           rsp_timeout, rsp_latency, stray_resp} !== 84'h0) begin
         errors++; $display("FAIL reset_values: got cmd=%h data=%h ready=%b valid=%b code=%0d rdata=%h tag=%0d to=%b lat=%0d stray=%b want all 0",
                            port_cmd, port_data, req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_timeout, rsp_latency, stray_resp);
      end
      reset = 1'b0;
      step();
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_add();
      run_txn(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd2, 3, 2'd1, 32'h2000_0000, 1'b0);
      collect(0);
   endtask

   task automatic test_underflow_invalid();
      run_txn(4'd2, 32'h1, 32'hF, 2'd1, 1, 2'd2, 32'h0, 1'b0);
      collect(0);
      run_txn(4'd3, 32'h1234_5678, 32'h9, 2'd0, 1, 2'd2, 32'h0, 1'b0);
      collect(0);
      run_txn(4'd4, 32'hAAAA_0000, 32'h5555, 2'd3, 2, 2'd2, 32'h0, 1'b0);
      collect(0);
   endtask

   task automatic test_timeout();
      run_txn(4'd5, 32'h3, 32'h4, 2'd1, 0, 2'd0, 32'h0, 1'b0);
      collect(0);
   endtask

   task automatic test_back_to_back();
      run_txn(4'd1, 32'h5, 32'h7, 2'd2, 1, 2'd1, 32'h0000_000C, 1'b0);
      // Second request waits on the handshake while the response is stalled.
      req_valid = 1'b1; req_cmd = 4'd2; req_op1 = 32'h9; req_op2 = 32'h3; req_tag = 2'd1;
      collect(5);
      checks++;
      if (port_cmd !== 4'h0 || port_data !== 32'h0) begin
         errors++; $display("FAIL early_accept: got cmd=%h data=%h want 0/0", port_cmd, port_data);
      end
      run_txn(4'd2, 32'h9, 32'h3, 2'd1, 2, 2'd1, 32'h6, 1'b0);
      collect(0);
   endtask

   task automatic test_stray();
      port_resp = 2'd1; port_dout = 32'hFFFF_FFFF;
      step();
      port_resp = '0; port_dout = '0;
      checks++;
      if (stray_resp !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL stray_idle: got stray=%b valid=%b want 1/0", stray_resp, rsp_valid);
      end
      step();
      checks++;
      if (stray_resp !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL stray_idle_clear: got stray=%b valid=%b want 0/0", stray_resp, rsp_valid);
      end
      run_txn(4'd1, 32'h10, 32'h20, 2'd3, 2, 2'd1, 32'h30, 1'b1);
      collect(0);
   endtask

   task automatic test_reset_mid_wait();
      int seen;
      req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'h1; req_op2 = 32'h2; req_tag = 2'd2;
      step();
      req_valid = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      checks++;
      if ({port_cmd, port_data, req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag,
           rsp_timeout, rsp_latency, stray_resp} !== 84'h0) begin
         errors++; $display("FAIL midwait_reset_values: got cmd=%h data=%h ready=%b valid=%b code=%0d rdata=%h tag=%0d to=%b lat=%0d stray=%b want all 0",
                            port_cmd, port_data, req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_timeout, rsp_latency, stray_resp);
      end
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 * TO; i++) begin
         step();
         if (rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL aborted_rsp: got %0d valid cycles want 0", seen); end
      run_txn(4'd6, 32'h8000_0000, 32'h1, 2'd1, 1, 2'd1, 32'h4000_0000, 1'b0);
      collect(0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_underflow_invalid();
      test_timeout();
      test_back_to_back();
      test_stray();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion want finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "bench time limit");
   end

endmodule
